// File: rtl/conv_tile_sequencer.sv
// Conv layer tile sequencer: walks a layer tile by tile through
// WAIT_SA -> RUN -> FLUSH -> DRAIN, with a RUN watchdog and abort.
// Ports: clk/rst_n (async active-low); start_i + num_tiles_i launch a
//   layer; abort_i forces IDLE; sa_ready_i, mover_done_i, glb_empty_i
//   are handshakes from the array, mover and GLB; mover_en_o,
//   tile_idx_o, busy_o, done_o, err_o are Moore-decoded outputs.
module conv_tile_sequencer #(
  parameter int TILE_W    = 8,
  parameter int DRAIN_CYC = 32,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [TILE_W-1:0] num_tiles_i,
  input  logic              abort_i,
  input  logic              sa_ready_i,
  input  logic              mover_done_i,
  input  logic              glb_empty_i,
  output logic              mover_en_o,
  output logic [TILE_W-1:0] tile_idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAIT_SA = 3'd1;
  localparam logic [2:0] RUN     = 3'd2;
  localparam logic [2:0] FLUSH   = 3'd3;
  localparam logic [2:0] DRAIN   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int DR_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [DR_W-1:0] DR_LOAD = DR_W'(DRAIN_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [TILE_W-1:0] num_tiles_q, num_tiles_d;
  logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic [DR_W-1:0]   drain_q, drain_d;
  logic              err_q, err_d;

  logic              last_tile;

  assign last_tile = (tile_idx_q == TILE_W'(num_tiles_q - TILE_W'(1)));

  always_comb begin
    state_d     = state_q;
    num_tiles_d = num_tiles_q;
    tile_idx_d  = tile_idx_q;
    wdog_d      = wdog_q;
    drain_d     = drain_q;
    err_d       = err_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            num_tiles_d = num_tiles_i;
            tile_idx_d  = '0;
            err_d       = 1'b0;
            state_d     = (num_tiles_i == '0) ? DONE : WAIT_SA;
          end
        end
        WAIT_SA: begin
          if (sa_ready_i) begin
            state_d = RUN;
            wdog_d  = '0;
          end
        end
        RUN: begin
          // A mover_done in the expiry cycle still counts as success.
          if (mover_done_i) begin
            state_d = FLUSH;
          end else if (wdog_q == WD_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
        end
        FLUSH: begin
          if (glb_empty_i) begin
            state_d = DRAIN;
            drain_d = DR_LOAD;
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            if (last_tile) begin
              state_d = DONE;
            end else begin
              tile_idx_d = tile_idx_q + TILE_W'(1);
              state_d    = WAIT_SA;
            end
          end else begin
            drain_d = drain_q - DR_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_tiles_q <= '0;
      tile_idx_q  <= '0;
      wdog_q      <= '0;
      drain_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_tiles_q <= num_tiles_d;
      tile_idx_q  <= tile_idx_d;
      wdog_q      <= wdog_d;
      drain_q     <= drain_d;
      err_q       <= err_d;
    end
  end

  assign mover_en_o = (state_q == RUN);
  assign tile_idx_o = tile_idx_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign err_o      = err_q;

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Scoreboard bench for conv_tile_sequencer: stimulus pushes expected
// mover windows / done / error events, a monitor pops and compares.
module tb_conv_tile_sequencer;

  localparam int TILE_W = 8;
  localparam int DRAIN_CYC = 4;
  localparam int TIMEOUT = 16;

  localparam int EV_WIN = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR = 2;

  logic              clk;
  logic              rst_n;
  logic              start_i;
  logic [TILE_W-1:0] num_tiles_i;
  logic              abort_i;
  logic              sa_ready_i;
  logic              mover_done_i;
  logic              glb_empty_i;
  logic              mover_en_o;
  logic [TILE_W-1:0] tile_idx_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  conv_tile_sequencer #(
    .TILE_W(TILE_W),
    .DRAIN_CYC(DRAIN_CYC),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start_i),
    .num_tiles_i(num_tiles_i),
    .abort_i(abort_i),
    .sa_ready_i(sa_ready_i),
    .mover_done_i(mover_done_i),
    .glb_empty_i(glb_empty_i),
    .mover_en_o(mover_en_o),
    .tile_idx_o(tile_idx_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
  );

  typedef struct {
    int kind;
    int gap;
    int len;
    int idx;
  } ev_t;

  ev_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;

  int run_len = 10;
  int glb_hold = 0;
  int hold_tile = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "global timeout");
  end

  function automatic void chk(input string name, input int act,
                              input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endfunction

  function automatic void push(input int kind, input int gap,
                               input int len, input int idx);
    ev_t e;
    e.kind = kind;
    e.gap = gap;
    e.len = len;
    e.idx = idx;
    exp_q.push_back(e);
  endfunction

  function automatic void check_evt(input int kind, input int gap,
                                    input int len, input int idx);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event act=kind%0d/gap%0d/len%0d/idx%0d req=none",
               kind, gap, len, idx);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.gap != gap || e.len != len ||
          e.idx != idx) begin
        n_fail++;
        $display("FAIL event act=kind%0d/gap%0d/len%0d/idx%0d req=kind%0d/gap%0d/len%0d/idx%0d",
                 kind, gap, len, idx, e.kind, e.gap, e.len, e.idx);
      end
    end
  endfunction

  // Responder: mover_done in the run_len-th RUN cycle, and optionally
  // hold glb_empty low for glb_hold FLUSH cycles after tile hold_tile.
  initial begin
    int run_cnt;
    int h;
    run_cnt = 0;
    mover_done_i = 1'b0;
    glb_empty_i = 1'b1;
    forever begin
      @(negedge clk);
      if (!mover_en_o) begin
        run_cnt = 0;
      end else begin
        run_cnt++;
        if (run_len != 0 && run_cnt == run_len) begin
          h = (int'(tile_idx_o) == hold_tile) ? glb_hold : 0;
          mover_done_i = 1'b1;
          @(negedge clk);
          mover_done_i = 1'b0;
          run_cnt = 0;
          glb_empty_i = (h == 0);
          repeat (h) @(negedge clk);
          glb_empty_i = 1'b1;
        end
      end
    end
  end

  // Monitor: reports each mover_en window (busy gap before it, length,
  // tile index), each done_o cycle and each err_o rise.
  initial begin
    bit in_win;
    bit err_prev;
    int wlen;
    int wgap;
    int widx;
    int gap;
    in_win = 0;
    err_prev = 0;
    wlen = 0;
    wgap = 0;
    widx = 0;
    gap = 0;
    forever begin
      @(negedge clk);
      if (mover_en_o) begin
        if (!in_win) begin
          in_win = 1;
          wlen = 0;
          widx = int'(tile_idx_o);
          wgap = gap;
        end
        wlen++;
      end else begin
        if (in_win) begin
          in_win = 0;
          check_evt(EV_WIN, wgap, wlen, widx);
          gap = 0;
        end
        gap = busy_o ? gap + 1 : 0;
      end
      if (done_o) check_evt(EV_DONE, 0, 0, int'(tile_idx_o));
      if (err_o && !err_prev) check_evt(EV_ERR, 0, 0, int'(tile_idx_o));
      err_prev = err_o;
    end
  end

  task automatic start_layer(input int n);
    @(negedge clk);
    start_i = 1'b1;
    num_tiles_i = TILE_W'(n);
    @(negedge clk);
    start_i = 1'b0;
    num_tiles_i = 8'hA5;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget) begin
      @(negedge clk);
      #1;
      if (!busy_o && exp_q.size() == 0) break;
      k++;
    end
    chk({name, "_idle_in_budget"}, int'(k < budget), 1);
  endtask

  task automatic wait_mover(input string name, input bit lvl,
                            input int idx, input bit use_idx);
    int k;
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (mover_en_o == lvl && (!use_idx || int'(tile_idx_o) == idx))
        break;
      k++;
    end
    chk({name, "_seen_in_budget"}, int'(k < 200), 1);
  endtask

  initial begin
    rst_n = 1'b1;
    start_i = 1'b0;
    num_tiles_i = '0;
    abort_i = 1'b0;
    sa_ready_i = 1'b1;
    #3;
    rst_n = 1'b0;
    #4;
    chk("rst_mover_en", int'(mover_en_o), 0);
    chk("rst_tile_idx", int'(tile_idx_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_err", int'(err_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Three tiles, 10-cycle runs; a second start mid-layer is ignored.
    push(EV_WIN, 1, 10, 0);
    push(EV_WIN, 2 + DRAIN_CYC, 10, 1);
    push(EV_WIN, 2 + DRAIN_CYC, 10, 2);
    push(EV_DONE, 0, 0, 2);
    start_layer(3);
    repeat (15) @(negedge clk);
    start_i = 1'b1;
    num_tiles_i = 8'd7;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle("three_tiles", 200);
    chk("three_tiles_busy_after", int'(busy_o), 0);

    // Zero-tile layer: straight to done, no mover activity.
    push(EV_DONE, 0, 0, 0);
    start_layer(0);
    wait_idle("zero_tiles", 20);

    // Watchdog: mover never finishes.
    run_len = 0;
    push(EV_WIN, 1, TIMEOUT, 0);
    push(EV_ERR, 0, 0, 0);
    start_layer(2);
    wait_idle("timeout", 100);
    chk("timeout_err_sticky", int'(err_o), 1);
    run_len = 10;

    // Back-pressure: sa_ready low 5 cycles, glb_empty low 7 cycles.
    hold_tile = 0;
    glb_hold = 7;
    push(EV_WIN, 1 + 5, 10, 0);
    push(EV_WIN, 2 + DRAIN_CYC + 7, 10, 1);
    push(EV_DONE, 0, 0, 1);
    sa_ready_i = 1'b0;
    start_layer(2);
    chk("start_clears_err", int'(err_o), 0);
    repeat (4) @(negedge clk);
    @(negedge clk);
    sa_ready_i = 1'b1;
    wait_idle("backpressure", 200);
    glb_hold = 0;

    // Abort in the third RUN cycle of tile 1 of 4.
    push(EV_WIN, 1, 10, 0);
    push(EV_WIN, 2 + DRAIN_CYC, 3, 1);
    start_layer(4);
    wait_mover("abort_tile1", 1'b1, 1, 1'b1);
    repeat (2) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_mover_en", int'(mover_en_o), 0);
    chk("abort_err_unchanged", int'(err_o), 0);
    wait_idle("abort", 20);

    // Abort overrides start in IDLE.
    @(negedge clk);
    start_i = 1'b1;
    num_tiles_i = 8'd3;
    abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("abort_over_start_busy", int'(busy_o), 0);

    // Asynchronous reset in the second DRAIN cycle of tile 0.
    push(EV_WIN, 1, 10, 0);
    start_layer(2);
    wait_mover("rst_drain_run", 1'b1, 0, 1'b0);
    wait_mover("rst_drain_flush", 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_mover_en", int'(mover_en_o), 0);
    chk("mid_rst_tile_idx", int'(tile_idx_o), 0);
    chk("mid_rst_done", int'(done_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle("mid_rst", 20);

    // Single tile after reset.
    push(EV_WIN, 1, 10, 0);
    push(EV_DONE, 0, 0, 0);
    start_layer(1);
    wait_idle("one_tile", 100);

    repeat (3) @(negedge clk);
    chk("leftover_events", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
